// File: rtl/urllc_sender_framer.sv
// Multi-lane sender framer: latches CHANNELS ADC lanes, frames them as preamble/payload/parity
// and serialises each bit onto the DAC bus as OOK levels or a two-tone BFSK square wave.
module urllc_sender_framer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned PRE_W          = 8,
    parameter logic [PRE_W-1:0] PREAMBLE  = 8'hD5,
    parameter int unsigned CYCLES_PER_BIT = 30,
    parameter int unsigned GAP_CYCLES     = 12,
    parameter logic [DATA_W-1:0] DA_HIGH  = 8'hF0,
    parameter logic [DATA_W-1:0] DA_LOW   = 8'h10,
    parameter logic [DATA_W-1:0] DA_IDLE  = 8'h80,
    parameter int unsigned HALF_F0        = 5,
    parameter int unsigned HALF_F1        = 3,
    parameter int unsigned COUNT_W        = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sync_in,
    input  logic                       mode,
    input  logic [CHANNELS*DATA_W-1:0] ad,
    output logic [DATA_W-1:0]          da,
    output logic                       sync_out,
    output logic                       busy,
    output logic [COUNT_W-1:0]         frame_count
);

    localparam int unsigned PAY_W      = CHANNELS * DATA_W;
    localparam int unsigned FRAME_BITS = PRE_W + PAY_W + 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned CNT_LIM    = (CYCLES_PER_BIT > GAP_CYCLES) ? CYCLES_PER_BIT
                                                                       : GAP_CYCLES;
    localparam int unsigned CYC_W      = $clog2(CNT_LIM + 1);
    localparam int unsigned HALF_MAX   = (HALF_F0 > HALF_F1) ? HALF_F0 : HALF_F1;
    localparam int unsigned PH_W       = $clog2(HALF_MAX + 1);

    localparam logic [BIT_W-1:0] LAST_PRE = BIT_W'(PRE_W - 1);
    localparam logic [BIT_W-1:0] LAST_PAY = BIT_W'(PRE_W + PAY_W - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CYCLES_PER_BIT - 1);
    localparam logic [CYC_W-1:0] LAST_GAP = CYC_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_END0  = PH_W'(HALF_F0 - 1);
    localparam logic [PH_W-1:0]  PH_END1  = PH_W'(HALF_F1 - 1);

    typedef enum logic [2:0] {StIdle, StPreamble, StPayload, StParity, StGap} state_e;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  mode_q, mode_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic                  tone_q, tone_d;
    logic [COUNT_W-1:0]    count_q, count_d;

    logic [PAY_W-1:0]      payload;
    logic                  start;
    logic                  cur_bit;
    logic [PH_W-1:0]       ph_end;

    // ch0 goes out first, so it occupies the most significant slice of the payload
    always_comb begin
        payload = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            payload[(CHANNELS-1-c)*DATA_W +: DATA_W] = ad[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        ph_d    = ph_q;
        tone_d  = tone_q;
        count_d = count_q;
        start   = 1'b0;
        cur_bit = frame_q[FRAME_BITS-1];
        ph_end  = cur_bit ? PH_END1 : PH_END0;

        if (ph_q == ph_end) begin
            ph_d   = '0;
            tone_d = ~tone_q;
        end else begin
            ph_d = ph_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (sync_in) start = 1'b1;
            end
            StPreamble, StPayload, StParity: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == LAST_CYC) begin
                    cyc_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    frame_d = frame_q << 1;
                    ph_d    = '0;
                    tone_d  = 1'b1;
                    if (state_q == StPreamble && bit_q == LAST_PRE) begin
                        state_d = StPayload;
                    end else if (state_q == StPayload && bit_q == LAST_PAY) begin
                        state_d = StParity;
                    end else if (state_q == StParity) begin
                        count_d = count_q + 1'b1;
                        if (GAP_CYCLES != 0) begin
                            state_d = StGap;
                        end else if (sync_in) begin
                            start = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StGap: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == LAST_GAP) begin
                    if (sync_in) start = 1'b1;
                    else state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d = StPreamble;
            frame_d = {PREAMBLE, payload, ^payload};
            mode_d  = mode;
            bit_d   = '0;
            cyc_d   = '0;
            ph_d    = '0;
            tone_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            frame_q <= '0;
            mode_q  <= 1'b0;
            bit_q   <= '0;
            cyc_q   <= '0;
            ph_q    <= '0;
            tone_q  <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            ph_q    <= ph_d;
            tone_q  <= tone_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        da = DA_IDLE;
        if (state_q == StPreamble || state_q == StPayload || state_q == StParity) begin
            if (mode_q) da = tone_q ? DA_HIGH : DA_LOW;
            else        da = cur_bit ? DA_HIGH : DA_LOW;
        end
    end

    assign sync_out    = (state_q == StPreamble) && (bit_q == '0) && (cyc_q == '0);
    assign busy        = (state_q != StIdle);
    assign frame_count = count_q;

endmodule
